result_uart_tx: RTL and testbench

Serializer stage directly downstream of the FSM/ALU core. It accepts one 16-bit ALU result per valid/ready handshake and transmits it on a single UART line, 8N1, high byte first. Its `tx` output drives the chip-level `tx` pin. `busy` is the core's `uart_busy` back-pressure signal.

---
 rtl/result_uart_tx.sv | 142 ++++++++++++++
 tb/tb_result_uart_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// result_uart_tx: 16-bit result serializer onto a UART line, high byte first.
//
// Each byte is sent as start bit, 8 data bits LSB first, optional even-parity
// bit, stop bit. Both bytes of a word go back-to-back; consecutive words are
// separated by one idle-high cycle when valid is held.
//
// Optional feature macro: RESULT_UART_PARITY_EN (adds an even-parity bit
// between data bit 7 and the stop bit).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ena        block enable; 0 freezes all state
//   data_in    16-bit word to transmit
//   valid_in   data_in is valid
//   ready_out  block can accept a word (idle only)
//   tx         UART serial output, idle high
//   busy       frame in progress (~ready_out)
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        tx,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef RESULT_UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       hold_lo;   // low byte, sent after the high byte
    logic             byte_sel;  // 0: high byte in flight, 1: low byte
`ifdef RESULT_UART_PARITY_EN
    logic             parity;    // even parity of the byte in flight
`endif

    assign busy = ~ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            hold_lo   <= '0;
            byte_sel  <= 1'b0;
            tx        <= 1'b1;
            ready_out <= 1'b1;
`ifdef RESULT_UART_PARITY_EN
            parity    <= 1'b0;
`endif
        end else if (ena) begin
            if (state == StIdle) begin
                tx <= 1'b1;
                if (valid_in) begin
                    // The high byte goes straight into the shifter; only the
                    // low byte needs holding.
                    state     <= StStart;
                    tx        <= 1'b0;
                    ready_out <= 1'b0;
                    byte_sel  <= 1'b0;
                    bit_cnt   <= '0;
                    bit_idx   <= '0;
                    shift_reg <= data_in[15:8];
                    hold_lo   <= data_in[7:0];
`ifdef RESULT_UART_PARITY_EN
                    parity    <= ^data_in[15:8];
`endif
                end
            end else if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
                // Bit boundary: tx is loaded with the next bit's level so it
                // changes exactly on the boundary edge.
                bit_cnt <= '0;
                case (state)
                    StStart: begin
                        state <= StData;
                        tx    <= shift_reg[0];
                    end
                    StData: begin
                        if (bit_idx == 3'd7) begin
`ifdef RESULT_UART_PARITY_EN
                            state <= StParity;
                            tx    <= parity;
`else
                            state <= StStop;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end
`ifdef RESULT_UART_PARITY_EN
                    StParity: begin
                        state <= StStop;
                        tx    <= 1'b1;
                    end
`endif
                    StStop: begin
                        if (!byte_sel) begin
                            state     <= StStart;
                            tx        <= 1'b0;
                            byte_sel  <= 1'b1;
                            bit_idx   <= '0;
                            shift_reg <= hold_lo;
`ifdef RESULT_UART_PARITY_EN
                            parity    <= ^hold_lo;
`endif
                        end else begin
                            state     <= StIdle;
                            tx        <= 1'b1;
                            ready_out <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= StIdle;
                        tx        <= 1'b1;
                        ready_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed testbench for result_uart_tx with CLKS_PER_BIT=4.
// Follows RESULT_UART_PARITY_EN to pick the expected frame length.
module tb_result_uart_tx;

    localparam int N = 4;
`ifdef RESULT_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [15:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    result_uart_tx #(
        .CLKS_PER_BIT(N),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    // Expected line level for frame bit b (0..2*FB-1) of word w.
    function automatic logic fbit(input logic [15:0] w, input int b);
        logic [7:0] by;
        int         k;
        by = (b < FB) ? w[15:8] : w[7:0];
        k  = b % FB;
        if (k == 0) return 1'b0;
        else if (k <= 8) return by[k-1];
        else if (k == 9 && FB == 11) return ^by;
        else return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive valid with w; returns 1ns after the accepting edge.
    task automatic accept(input logic [15:0] w);
        data_in  = w;
        valid_in = 1'b1;
        check("ready_before_accept", ready_out, 1'b1);
        tick();
        check("ready_after_accept", ready_out, 1'b0);
    endtask

    // Check ncyc frame cycles; optionally stall ena for 7 cycles at stall_pos.
    task automatic run_frame(input logic [15:0] w, input int stall_pos, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (c == stall_pos) begin
                ena = 1'b0;
                for (int s = 0; s < 7; s++) begin
                    tick();
                    check("stall_tx", tx, fbit(w, c / N));
                    check("stall_busy", busy, 1'b1);
                end
                ena = 1'b1;
            end
            check("tx", tx, fbit(w, c / N));
            check("busy", busy, 1'b1);
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, tx, 1'b1);
        check({tag, "_ready"}, ready_out, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        valid_in = 1'b0;
        data_in  = 16'h0000;

        // Reset state
        tick();
        tick();
        check_idle("in_reset");
        rst_n = 1'b1;
        tick();
        check_idle("after_reset");

        // Single word 0x12A5
        accept(16'h12A5);
        valid_in = 1'b0;
        run_frame(16'h12A5, -1, 2 * FB * N);
        check_idle("single_end");

        // Back-to-back FFFF then 0000 with one idle cycle between
        accept(16'hFFFF);
        data_in = 16'h0000;
        run_frame(16'hFFFF, -1, 2 * FB * N);
        check_idle("b2b_gap");
        tick();
        check("b2b_second_accept", ready_out, 1'b0);
        valid_in = 1'b0;
        run_frame(16'h0000, -1, 2 * FB * N);
        check_idle("b2b_end");

        // data_in changes after acceptance
        accept(16'h00FF);
        data_in  = 16'hDEAD;
        valid_in = 1'b0;
        run_frame(16'h00FF, -1, 2 * FB * N);
        check_idle("stable_end");

        // ena stall inside data bit 3 of the high byte (frame bit 4)
        accept(16'hC35A);
        valid_in = 1'b0;
        run_frame(16'hC35A, 4 * N + 1, 2 * FB * N);
        check_idle("stall_end");

        // Parity vector (frame length follows the build)
        accept(16'h0301);
        valid_in = 1'b0;
        run_frame(16'h0301, -1, 2 * FB * N);
        check_idle("parity_end");

        // Asynchronous reset at cycle 30 of a frame
        accept(16'h5A3C);
        valid_in = 1'b0;
        run_frame(16'h5A3C, -1, 30);
        check("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        #2;
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");
        tick();
        check_idle("post_reset2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
